// File: rtl/mvu_pkg.sv
// mvu_pkg: shared constants and types for the MVU datapath blocks.
//
// Contents used by the quantiser/serialiser:
//   N, BSCALERP, BQMSBIDX, QBWOUTBD, BDBANKA  - datapath and config widths
//   quantser_state_t                          - serialiser FSM states
//   qs_lane_arr_t                             - N lane register images
//   qs_top_plane / qs_shift_planes            - bit-plane extract / advance
package mvu_pkg;

  localparam int N        = 64;  // lanes per vector, equals data bank word width
  localparam int BSCALERP = 48;  // bits per scaler result lane
  localparam int BQMSBIDX = 6;   // msbidx config field width
  localparam int QBWOUTBD = 6;   // bdout config field width
  localparam int BDBANKA  = 15;  // data bank address width

  typedef enum logic {QS_IDLE, QS_SER} quantser_state_t;

  // One window-aligned image per lane; the next bit-plane to emit always
  // sits at bit BSCALERP-1 of every lane.
  typedef logic [N-1:0][BSCALERP-1:0] qs_lane_arr_t;

  // Gather the current top bit of every lane into one bit-plane word.
  function automatic logic [N-1:0] qs_top_plane(input qs_lane_arr_t v);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w[k] = v[k][BSCALERP-1];
    end
    return w;
  endfunction

  // Move every lane up by one plane; zeros fill from below so planes past
  // the effective window read back as 0.
  function automatic qs_lane_arr_t qs_shift_planes(input qs_lane_arr_t v);
    qs_lane_arr_t r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      r[k] = {v[k][BSCALERP-2:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/mvu_quant_lane.sv
// mvu_quant_lane: combinational saturate + window-align for one lane.
//
// Ports:
//   lane_in  in   BSCALERP  two's complement scaler result
//   msb      in   BQMSBIDX  window MSB bit index, already clamped to BSCALERP-1
//   bdout    in   QBWOUTBD  requested number of output bit-planes
//   img      out  BSCALERP  window placed at the top of the word, MSB at bit
//                           BSCALERP-1, everything below the effective window 0
module mvu_quant_lane
  import mvu_pkg::*;
(
  input  logic [BSCALERP-1:0] lane_in,
  input  logic [BQMSBIDX-1:0] msb,
  input  logic [QBWOUTBD-1:0] bdout,
  output logic [BSCALERP-1:0] img
);

  localparam logic [BSCALERP-1:0] TOP_BIT = {1'b1, {(BSCALERP-1){1'b0}}};

  logic [BSCALERP-1:0] hi_bits;
  logic [BSCALERP-1:0] win_mask;
  logic [BSCALERP-1:0] raw_img;
  logic [QBWOUTBD:0]   avail_bits;
  logic [QBWOUTBD:0]   eff_bits;
  logic [BQMSBIDX-1:0] align_sh;
  logic                sat;

  always_comb begin
    // Bits [BSCALERP-1:msb] must be a pure sign extension for the value to
    // fit a signed window whose MSB is bit msb.
    hi_bits = BSCALERP'($signed(lane_in) >>> msb);
    sat     = (hi_bits != '0) && (hi_bits != '1);

    // Only msb+1 real bits exist at or below the window MSB; deeper planes
    // are forced to zero and saturation is confined to what remains.
    avail_bits = (QBWOUTBD+1)'(msb) + (QBWOUTBD+1)'(1);
    eff_bits   = ({1'b0, bdout} < avail_bits) ? {1'b0, bdout} : avail_bits;
    win_mask   = ~({BSCALERP{1'b1}} >> eff_bits);

    align_sh = BQMSBIDX'(BSCALERP-1) - msb;
    raw_img  = (lane_in << align_sh) & win_mask;

    img = raw_img;
    if (sat) begin
      if (lane_in[BSCALERP-1]) begin
        img = TOP_BIT & win_mask;
      end else begin
        img = win_mask & ~TOP_BIT;
      end
    end
  end

endmodule

// File: rtl/mvu_quantser.sv
// mvu_quantser: quantise one vector of scaler results and serialise it,
// MSB-first, as bit-plane words for a data bank write port.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  vector handshake; ready only while idle
//   in_data         N lanes of BSCALERP bits, lane i at [i*BSCALERP +: BSCALERP]
//   cfg_msbidx      window MSB index, sampled on accept
//   cfg_bdout       number of bit-planes to emit, sampled on accept
//   cfg_baddr       address of the first bit-plane, sampled on accept
//   out_valid/ready bit-plane word handshake
//   out_word        bit k = current plane bit of lane k
//   out_addr        write address of out_word, wraps modulo 2^BDBANKA
//   out_last        final plane of the vector
//   busy            serialisation in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// QS_IDLE | waiting for a vector; in_ready=1, no word presented
// QS_SER  | presenting planes; advance on each out_valid&out_ready
module mvu_quantser
  import mvu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*BSCALERP-1:0] in_data,
  input  logic [BQMSBIDX-1:0]   cfg_msbidx,
  input  logic [QBWOUTBD-1:0]   cfg_bdout,
  input  logic [BDBANKA-1:0]    cfg_baddr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_word,
  output logic [BDBANKA-1:0]    out_addr,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [BQMSBIDX-1:0] MSB_MAX = BQMSBIDX'(BSCALERP-1);

  quantser_state_t      state_q, state_d;
  qs_lane_arr_t         lane_q, lane_d;
  qs_lane_arr_t         lane_img;
  logic [QBWOUTBD-1:0]  left_q, left_d;   // planes still to present after the current one
  logic [N-1:0]         word_q, word_d;
  logic [BDBANKA-1:0]   addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [BQMSBIDX-1:0]  msb_clamp;
  logic                 accept;
  logic                 out_hs;

  assign msb_clamp = (cfg_msbidx > MSB_MAX) ? MSB_MAX : cfg_msbidx;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mvu_quant_lane u_lane (
      .lane_in (in_data[i*BSCALERP +: BSCALERP]),
      .msb     (msb_clamp),
      .bdout   (cfg_bdout),
      .img     (lane_img[i])
    );
  end

  assign accept = (state_q == QS_IDLE) && in_valid;
  assign out_hs = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    left_d  = left_q;
    word_d  = word_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;

    case (state_q)
      QS_IDLE: begin
        // bdout==0 consumes the vector without producing anything.
        if (accept && (cfg_bdout != '0)) begin
          word_d  = qs_top_plane(lane_img);
          lane_d  = qs_shift_planes(lane_img);
          addr_d  = cfg_baddr;
          left_d  = cfg_bdout - QBWOUTBD'(1);
          last_d  = (cfg_bdout == QBWOUTBD'(1));
          valid_d = 1'b1;
          state_d = QS_SER;
        end
      end
      QS_SER: begin
        if (out_hs) begin
          if (last_q) begin
            word_d  = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            state_d = QS_IDLE;
          end else begin
            word_d = qs_top_plane(lane_q);
            lane_d = qs_shift_planes(lane_q);
            addr_d = addr_q + BDBANKA'(1);
            left_d = left_q - QBWOUTBD'(1);
            last_d = (left_q == QBWOUTBD'(1));
          end
        end
      end
      default: begin
        state_d = QS_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= QS_IDLE;
      lane_q  <= '0;
      left_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      left_q  <= left_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == QS_IDLE);
  assign busy      = (state_q == QS_SER);
  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;

endmodule
